// File: rtl/key_out_pkg.sv
// key_out_pkg: keypoint record layout, serializer states and word packing.
package key_out_pkg;
  typedef struct packed {
    logic [11:0] sin;
    logic [11:0] cos;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  score;
    logic [15:0] depth;
  } rec_t;
  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_TRL} state_t;
  localparam logic [3:0] HDR_REC = 4'hA;
  localparam logic [3:0] HDR_TRL = 4'hF;
  function automatic logic [31:0] pack_word(input rec_t r, input logic [1:0] sel);
    return sel == 2'd0 ? {HDR_REC, r.x, r.y, r.score} :
           sel == 2'd1 ? {r.sin, r.cos, 8'h00} : {16'h0000, r.depth};
  endfunction
  function automatic logic [31:0] pack_trl(input logic [15:0] cnt);
    return {HDR_TRL, 12'h000, cnt};
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return c == 16'hFFFF ? c : c + 16'd1;
  endfunction
endpackage

// File: rtl/key_rec_fifo.sv
// key_rec_fifo: show-ahead synchronous FIFO; caller never pushes when full without popping.
module key_rec_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 68,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_occ
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  assign o_full = o_occ == (AW+1)'(DEPTH);
  assign o_empty = o_occ == '0;
  assign o_dout = mem[rd_q];
  always_ff @(posedge i_clk)
    if (i_push) mem[wr_q] <= i_din;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      o_occ <= '0;
    end else begin
      wr_q <= wr_q + AW'(i_push);
      rd_q <= rd_q + AW'(i_pop);
      o_occ <= o_occ + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
endmodule

// File: rtl/key_out_serializer.sv
// key_out_serializer: queues keypoint records and streams them as 3 words each plus a per-frame trailer.
module key_out_serializer
  import key_out_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit DROP_EMPTY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hit,
  input  logic [11:0] i_sin,
  input  logic [11:0] i_cos,
  input  logic [9:0]  i_coor_x,
  input  logic [9:0]  i_coor_y,
  input  logic [7:0]  i_score,
  input  logic [15:0] i_depth,
  input  logic        i_frame_end,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_overflow,
  output logic [15:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  rec_t in_rec, fifo_dout, hold_q;
  state_t state_q, state_d;
  logic want, push, pop, full, empty, fire, due, fe_ok, pending_q, valid_d, last_d;
  logic [31:0] data_d;
  logic [15:0] trl_q, cnt_inc;
  logic [AW:0] occ, occ_next, rem_q;
  assign in_rec = {i_sin, i_cos, i_coor_x, i_coor_y, i_score, i_depth};
  assign want = i_hit && (!DROP_EMPTY || i_score != 8'd0);
  assign push = want && (!full || pop);
  assign fire = o_valid && i_ready;
  assign due = pending_q && rem_q == '0;
  assign fe_ok = i_frame_end && !pending_q;
  assign cnt_inc = push ? sat_inc(o_count) : o_count;
  assign occ_next = occ + (AW+1)'(push) - (AW+1)'(pop);
  key_rec_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_push(push),
    .i_pop(pop),
    .i_din(in_rec),
    .o_dout(fifo_dout),
    .o_full(full),
    .o_empty(empty),
    .o_occ(occ)
  );
  // A due trailer beats queued records: those were pushed after the frame ended.
  always_comb begin
    state_d = state_q;
    valid_d = o_valid;
    data_d = o_data;
    last_d = o_last;
    pop = 1'b0;
    if (state_q == S_W0 && fire) begin
      state_d = S_W1;
      data_d = pack_word(hold_q, 2'd1);
    end else if (state_q == S_W1 && fire) begin
      state_d = S_W2;
      data_d = pack_word(hold_q, 2'd2);
    end else if (state_q == S_IDLE || ((state_q == S_W2 || state_q == S_TRL) && fire)) begin
      if (due && state_q != S_TRL) begin
        state_d = S_TRL;
        valid_d = 1'b1;
        data_d = pack_trl(trl_q);
        last_d = 1'b1;
      end else if (!empty) begin
        pop = 1'b1;
        state_d = S_W0;
        valid_d = 1'b1;
        data_d = pack_word(fifo_dout, 2'd0);
        last_d = 1'b0;
      end else begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d = 1'b0;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_IDLE;
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
      o_overflow <= 1'b0;
      o_count <= '0;
      hold_q <= '0;
      pending_q <= 1'b0;
      rem_q <= '0;
      trl_q <= '0;
    end else begin
      state_q <= state_d;
      o_valid <= valid_d;
      o_data <= data_d;
      o_last <= last_d;
      if (pop) hold_q <= fifo_dout;
      if ((want && !push) || (i_frame_end && pending_q)) o_overflow <= 1'b1;
      if (fe_ok) begin
        trl_q <= cnt_inc;
        o_count <= '0;
        pending_q <= 1'b1;
        rem_q <= occ_next;
      end else begin
        o_count <= cnt_inc;
        if (state_q == S_TRL && fire) pending_q <= 1'b0;
        if (pending_q && pop && rem_q != '0) rem_q <= rem_q - (AW+1)'(1);
      end
    end
endmodule
